// File: rtl/fix_mul_pipe.sv
`default_nettype none
// fix_mul_pipe: valid/ready pipelined signed fixed-point multiplier with optional
// round-half-up, saturate-or-wrap range handling and a saturating overflow counter.
module fix_mul_pipe #(
  parameter int WIDTH       = 16,
  parameter int POINT_WIDTH = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             round_en,
  input  logic             sat_en,
  output logic [WIDTH-1:0] outP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ovf,
  input  logic             ovf_clr,
  output logic [15:0]      ovf_cnt
);

  localparam logic [2*WIDTH:0] C_HALF = (2*WIDTH+1)'(1) << (POINT_WIDTH-1);

  logic                      w_adv;
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [2*WIDTH-1:0] w_src_prod;
  logic                      w_src_rnd;
  logic                      w_src_sat;
  logic                      w_src_vld;
  logic signed [2*WIDTH:0]   w_rnd;
  logic signed [2*WIDTH:0]   w_shift;
  logic [WIDTH+1:0]          w_hi;
  logic                      w_ovf;

  logic [WIDTH-1:0] out_p_d, out_p_q;
  logic             out_ovf_d, out_ovf_q;
  logic             out_valid_q;
  logic [15:0]      cnt_d, cnt_q;

  assign w_adv    = ~out_valid_q | out_ready;
  assign in_ready = w_adv;
  assign w_prod   = $signed({{WIDTH{inA[WIDTH-1]}}, inA}) * $signed({{WIDTH{inB[WIDTH-1]}}, inB});

  // The multiply occupies every stage except the last; the last stage does round/shift/range.
  generate
    if (PIPE_STAGES == 1) begin : g_direct
      assign w_src_prod = w_prod;
      assign w_src_rnd  = round_en;
      assign w_src_sat  = sat_en;
      assign w_src_vld  = in_valid;
    end else begin : g_piped
      logic signed [2*WIDTH-1:0] prod_q [PIPE_STAGES-1];
      logic [PIPE_STAGES-2:0]    rnd_q;
      logic [PIPE_STAGES-2:0]    sat_q;
      logic [PIPE_STAGES-2:0]    vld_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_q <= '0;
        end else if (w_adv) begin
          vld_q[0] <= in_valid;
          for (int i = 1; i < PIPE_STAGES-1; i++) vld_q[i] <= vld_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (w_adv) begin
          prod_q[0] <= w_prod;
          rnd_q[0]  <= round_en;
          sat_q[0]  <= sat_en;
          for (int i = 1; i < PIPE_STAGES-1; i++) begin
            prod_q[i] <= prod_q[i-1];
            rnd_q[i]  <= rnd_q[i-1];
            sat_q[i]  <= sat_q[i-1];
          end
        end
      end

      assign w_src_prod = prod_q[PIPE_STAGES-2];
      assign w_src_rnd  = rnd_q[PIPE_STAGES-2];
      assign w_src_sat  = sat_q[PIPE_STAGES-2];
      assign w_src_vld  = vld_q[PIPE_STAGES-2];
    end
  endgenerate

  assign w_rnd   = {w_src_prod[2*WIDTH-1], w_src_prod} + (w_src_rnd ? C_HALF : '0);
  assign w_shift = w_rnd >>> POINT_WIDTH;
  // In range exactly when all bits from the sign down to bit WIDTH-1 agree.
  assign w_hi    = w_shift[2*WIDTH:WIDTH-1];
  assign w_ovf   = ~((&w_hi) | ~(|w_hi));

  always_comb begin
    out_p_d   = '0;
    out_ovf_d = 1'b0;
    if (w_src_vld) begin
      out_ovf_d = w_ovf;
      if (w_ovf && w_src_sat) begin
        out_p_d = w_shift[2*WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        out_p_d = w_shift[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      out_ovf_q   <= 1'b0;
    end else if (w_adv) begin
      out_valid_q <= w_src_vld;
      out_p_q     <= out_p_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ovf_clr) begin
      cnt_d = '0;
    end else if (out_valid_q && out_ready && out_ovf_q && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign outP      = out_p_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;
  assign ovf_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fix_mul_pipe.sv
`default_nettype none
// tb_fix_mul_pipe: directed self-checking bench for fix_mul_pipe (16-bit, Q8, 2 stages).
module tb_fix_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] inA = '0;
  logic [15:0] inB = '0;
  logic        round_en = 1'b0;
  logic        sat_en = 1'b1;
  logic [15:0] outP;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_ovf;
  logic        ovf_clr = 1'b0;
  logic [15:0] ovf_cnt;

  int errors = 0;
  int checks = 0;

  fix_mul_pipe #(.WIDTH(16), .POINT_WIDTH(8), .PIPE_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inA(inA), .inB(inB), .round_en(round_en), .sat_en(sat_en),
    .outP(outP), .out_valid(out_valid), .out_ready(out_ready),
    .out_ovf(out_ovf), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single operand pair; result must appear exactly two edges after acceptance edge.
  task automatic one(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic r, input logic s, input logic [15:0] ep, input logic eo);
    inA = a; inB = b; round_en = r; sat_en = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_p"},   {16'd0, outP},      {16'd0, ep});
    chk({tag, "_ovf"}, {31'd0, out_ovf},   {31'd0, eo});
  endtask

  logic [15:0] sa [6];
  logic [15:0] se [6];
  int          idx;
  int          oidx;
  logic [15:0] held;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_p",   {16'd0, outP},      32'd0);
    chk("rst_ovf", {31'd0, out_ovf},   32'd0);
    chk("rst_cnt", {16'd0, ovf_cnt},   32'd0);
    rst_n = 1'b1;
    #1;
    chk("rdy_after_rst", {31'd0, in_ready}, 32'd1);

    one("mul_1p5x2",   16'h0180, 16'h0200, 1'b0, 1'b1, 16'h0300, 1'b0);
    one("mul_neg",     16'hFF00, 16'h0180, 1'b0, 1'b1, 16'hFE80, 1'b0);
    one("trunc_pos",   16'h0001, 16'h0080, 1'b0, 1'b1, 16'h0000, 1'b0);
    one("round_pos",   16'h0001, 16'h0080, 1'b1, 1'b1, 16'h0001, 1'b0);
    one("trunc_neg",   16'hFFFF, 16'h0080, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    one("round_neg",   16'hFFFF, 16'h0080, 1'b1, 1'b1, 16'h0000, 1'b0);
    one("max_inrange", 16'h7FFF, 16'h0100, 1'b0, 1'b1, 16'h7FFF, 1'b0);
    one("min_inrange", 16'h8000, 16'h0100, 1'b0, 1'b1, 16'h8000, 1'b0);
    chk("cnt_zero", {16'd0, ovf_cnt}, 32'd0);

    one("sat_pos",  16'h7F00, 16'h0200, 1'b0, 1'b1, 16'h7FFF, 1'b1);
    one("wrap_pos", 16'h7F00, 16'h0200, 1'b0, 1'b0, 16'hFE00, 1'b1);
    tick();
    chk("cnt_two", {16'd0, ovf_cnt}, 32'd2);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("cnt_clr", {16'd0, ovf_cnt}, 32'd0);

    one("sat_neg", 16'h8000, 16'h7FFF, 1'b0, 1'b1, 16'h8000, 1'b1);
    tick();
    chk("cnt_one", {16'd0, ovf_cnt}, 32'd1);

    // Six back-to-back operands with a three-cycle downstream stall.
    for (int k = 0; k < 6; k++) begin
      sa[k] = 16'((k + 1) * 256);
      se[k] = 16'((k + 1) * 512);
    end
    idx = 0;
    oidx = 0;
    held = '0;
    round_en = 1'b0;
    sat_en = 1'b1;
    inB = 16'h0200;
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready = !(cyc >= 3 && cyc < 6);
      in_valid  = (idx < 6);
      inA       = (idx < 6) ? sa[idx] : 16'h0000;
      #1;
      if (!out_ready) begin
        chk("stall_rdy", {31'd0, in_ready}, 32'd0);
        if (cyc == 3) held = outP;
        else chk("stall_hold", {16'd0, outP}, {16'd0, held});
      end
      if (out_valid && out_ready) begin
        if (oidx < 6) chk("stream_p", {16'd0, outP}, {16'd0, se[oidx]});
        oidx++;
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_cnt", oidx, 32'd6);
    chk("stream_idle", {31'd0, out_valid}, 32'd0);

    // Reset with two overflowing results in flight.
    inA = 16'h7F00; inB = 16'h0200; sat_en = 1'b1; in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_p",   {16'd0, outP},      32'd0);
    chk("mid_rst_cnt", {16'd0, ovf_cnt},   32'd0);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("no_stale", {31'd0, out_valid}, 32'd0);
    end
    chk("no_stale_cnt", {16'd0, ovf_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
